// File: rtl/output_queue_display.sv
// Display-side output queue: buffers W-bus loads and shows each one for a
// minimum number of clocks so back-to-back OUT instructions stay visible.
module output_queue_display #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                         CLK,
    input  logic                         nCLR,
    input  logic                         nLo,
    input  logic [WIDTH-1:0]             orin,
    output logic [WIDTH-1:0]             display,
    output logic                         new_val,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    display_q, display_d;
    logic                new_val_q, new_val_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                overflow_q, overflow_d;
    logic                pop_c;
    logic                push_c;

    logic [WIDTH-1:0]    mem [DEPTH];

    // Pop decision only looks at the registered count, so a value pushed on
    // this edge can never be popped on the same edge.
    always_comb begin
        pop_c = 1'b0;
        unique case (state_q)
            ST_IDLE,
            ST_READY: pop_c = (count_q != '0);
            ST_HOLD:  pop_c = (hold_q == '0) && (count_q != '0);
            default:  pop_c = 1'b0;
        endcase
        // A full queue still accepts a load when the head leaves on the same edge.
        push_c = !nLo && ((count_q != CNT_FULL) || pop_c);
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        display_d  = display_q;
        new_val_d  = 1'b0;
        overflow_d = overflow_q | (!nLo && !push_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            display_d = mem[rd_ptr_q];
            new_val_d = 1'b1;
            hold_d    = HOLD_RELOAD;
            state_d   = ST_HOLD;
        end else if (state_q == ST_HOLD) begin
            if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                state_d = ST_READY;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            display_q  <= '0;
            new_val_q  <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            display_q  <= display_d;
            new_val_q  <= new_val_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as pending.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr_q] <= orin;
        end
    end

    assign display  = display_q;
    assign new_val  = new_val_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
